// File: rtl/ahb_interconnect.sv
// Single-master, N-slave AHB-lite interconnect: address decoder, registered
// data-phase response mux, built-in ERROR default slave and wait-state watchdog.
module ahb_interconnect #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 11,
    parameter int IDX_W      = 2,
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [1:0]                   htrans,
    output logic [ADDR_W-IDX_W-1:0]      slv_haddr,
    output logic [NUM_SLAVES-1:0]        hsel_s,
    input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
    input  logic [NUM_SLAVES-1:0]        hreadyout_s,
    input  logic [NUM_SLAVES-1:0]        hresp_s,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hready,
    output logic                         hresp,
    output logic [7:0]                   err_cnt,
    output logic                         timeout_evt
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        DP_IDLE = 2'd0,
        DP_SLV  = 2'd1,
        DP_ERR1 = 2'd2,
        DP_ERR2 = 2'd3
    } dp_state_t;

    dp_state_t          state_reg, state_next, open_state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   dsel_reg;
    logic               dact_reg;
    logic [WCNT_W-1:0]  wcnt_reg;
    logic               abort_reg;
    logic [7:0]         err_cnt_reg;
    logic               mapped;
    logic               opens;
    logic               wd_abort;
    logic               slv_ready;
    logic               slv_resp;
    logic [DATA_W-1:0]  slv_data;

    assign idx       = haddr[ADDR_W-1 -: IDX_W];
    assign mapped    = (32'(idx) < NUM_SLAVES);
    assign opens     = (htrans == 2'b10) || (htrans == 2'b11);
    assign slv_haddr = haddr[ADDR_W-IDX_W-1:0];

    // Decode is purely combinational and deliberately not gated by htrans.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hsel
            assign hsel_s[gi] = mapped && (idx == IDX_W'(gi));
        end
    endgenerate

    // Response mux is steered by the registered data-phase select only.
    always_comb begin
        slv_ready = 1'b0;
        slv_resp  = 1'b0;
        slv_data  = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (dsel_reg == IDX_W'(k)) begin
                slv_ready = hreadyout_s[k];
                slv_resp  = hresp_s[k];
                slv_data  = hrdata_s[k*DATA_W +: DATA_W];
            end
        end
    end

    assign wd_abort = (TIMEOUT > 0) && (state_reg == DP_SLV) && !slv_ready &&
                      (wcnt_reg == WCNT_W'(TIMEOUT - 1));

    assign open_state = opens ? (mapped ? DP_SLV : DP_ERR1) : DP_IDLE;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg <= DP_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DP_IDLE: state_next = open_state;
            DP_SLV: begin
                if (slv_ready) begin
                    state_next = open_state;
                end else if (wd_abort) begin
                    state_next = DP_ERR1;
                end
            end
            DP_ERR1: state_next = DP_ERR2;
            DP_ERR2: state_next = open_state;
            default: state_next = DP_IDLE;
        endcase
    end

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        case (state_reg)
            DP_SLV: begin
                hready = slv_ready;
                hresp  = slv_resp;
                hrdata = slv_data;
            end
            DP_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            DP_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel_reg    <= '0;
            dact_reg    <= 1'b0;
            wcnt_reg    <= '0;
            abort_reg   <= 1'b0;
            err_cnt_reg <= 8'd0;
        end else begin
            if (hready) begin
                dsel_reg <= idx;
                dact_reg <= opens;
            end
            if ((state_reg == DP_SLV) && !hready) begin
                wcnt_reg <= wcnt_reg + 1'b1;
            end else begin
                wcnt_reg <= '0;
            end
            // Remember an abort until its ERR2 beat completes so the pulse lands there.
            if (wd_abort) begin
                abort_reg <= 1'b1;
            end else if (hready) begin
                abort_reg <= 1'b0;
            end
            if (dact_reg && hready && hresp && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign err_cnt     = err_cnt_reg;
    assign timeout_evt = (state_reg == DP_ERR2) && abort_reg;

endmodule

// File: tb/tb_ahb_interconnect.sv
// Randomised and directed checks of ahb_interconnect against a transfer-level
// reference model (3 mapped slaves, one unmapped region, watchdog of 8 cycles).
module tb_ahb_interconnect;

    localparam int DW = 8;
    localparam int AW = 11;
    localparam int IW = 2;
    localparam int NS = 3;
    localparam int TO = 8;

    logic              hclk = 1'b0;
    logic              hresetn;
    logic [AW-1:0]     haddr;
    logic [1:0]        htrans;
    logic [AW-IW-1:0]  slv_haddr;
    logic [NS-1:0]     hsel_s;
    logic [NS*DW-1:0]  hrdata_s;
    logic [NS-1:0]     hreadyout_s;
    logic [NS-1:0]     hresp_s;
    logic [DW-1:0]     hrdata;
    logic              hready;
    logic              hresp;
    logic [7:0]        err_cnt;
    logic              timeout_evt;
    logic [DW-1:0]     slv_data [NS];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the outstanding transfer, seen as a whole.
    bit m_busy;
    int m_tgt;
    int m_wait;
    int m_err;
    bit m_abort;
    int m_cnt;
    logic e_ready, e_resp;
    logic [DW-1:0] e_data;

    assign hrdata_s = {slv_data[2], slv_data[1], slv_data[0]};

    always #5 hclk = ~hclk;

    ahb_interconnect #(
        .DATA_W(DW), .ADDR_W(AW), .IDX_W(IW), .NUM_SLAVES(NS), .TIMEOUT(TO)
    ) dut (
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
        .slv_haddr(slv_haddr), .hsel_s(hsel_s), .hrdata_s(hrdata_s),
        .hreadyout_s(hreadyout_s), .hresp_s(hresp_s), .hrdata(hrdata),
        .hready(hready), .hresp(hresp), .err_cnt(err_cnt), .timeout_evt(timeout_evt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_tgt = 0; m_wait = 0; m_err = 0; m_abort = 0; m_cnt = 0;
    endtask

    task automatic model_check();
        int idx;
        idx = int'(haddr[AW-1 -: IW]);
        if (!m_busy) begin
            e_ready = 1'b1; e_resp = 1'b0; e_data = '0;
        end else if (m_err == 1) begin
            e_ready = 1'b0; e_resp = 1'b1; e_data = '0;
        end else if (m_err == 2) begin
            e_ready = 1'b1; e_resp = 1'b1; e_data = '0;
        end else begin
            e_ready = hreadyout_s[m_tgt]; e_resp = hresp_s[m_tgt]; e_data = slv_data[m_tgt];
        end
        check_val("hready", 32'(hready), 32'(e_ready));
        check_val("hresp", 32'(hresp), 32'(e_resp));
        check_val("hrdata", 32'(hrdata), 32'(e_data));
        check_val("err_cnt", 32'(err_cnt), m_cnt);
        check_val("timeout_evt", 32'(timeout_evt), 32'(m_err == 2 && m_abort));
        check_val("hsel_s", 32'(hsel_s), (idx < NS) ? (32'd1 << idx) : 32'd0);
        check_val("slv_haddr", 32'(slv_haddr), 32'(haddr[AW-IW-1:0]));
    endtask

    task automatic model_update();
        int idx;
        idx = int'(haddr[AW-1 -: IW]);
        if (m_busy && e_ready && e_resp && m_cnt < 255) m_cnt++;
        if (e_ready) begin
            m_busy  = htrans[1];
            m_tgt   = idx;
            m_wait  = 0;
            m_abort = 0;
            m_err   = (idx >= NS) ? 1 : 0;
        end else if (m_err == 1) begin
            m_err = 2;
        end else begin
            m_wait++;
            if (TO > 0 && m_wait == TO) begin
                m_err = 1;
                m_abort = 1;
            end
        end
    endtask

    task automatic half();
        @(negedge hclk);
        model_check();
    endtask

    task automatic tick();
        @(posedge hclk);
        model_update();
        #1;
    endtask

    task automatic step();
        half();
        tick();
    endtask

    task automatic set_addr(input int idx, input bit nonseq);
        logic [IW-1:0] i2;
        i2 = idx[IW-1:0];
        haddr  = {i2, (AW-IW)'($urandom)};
        htrans = nonseq ? 2'b10 : 2'b00;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic apply_reset();
        hresetn = 1'b0;
        #1;
        check_val("rst_hready", 32'(hready), 32'd1);
        check_val("rst_hresp", 32'(hresp), 32'd0);
        check_val("rst_hrdata", 32'(hrdata), 32'd0);
        check_val("rst_err_cnt", 32'(err_cnt), 32'd0);
        check_val("rst_timeout_evt", 32'(timeout_evt), 32'd0);
        model_reset();
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
    endtask

    initial begin
        int cnt0;
        int stall;
        hresetn = 1'b0;
        set_addr(0, 0);
        hreadyout_s = '1;
        hresp_s = '0;
        slv_data[0] = 8'hA5; slv_data[1] = 8'h11; slv_data[2] = 8'h3C;
        model_reset();
        #2;
        apply_reset();

        // Pipelined reads to two different slaves
        set_addr(0, 1); step();
        set_addr(2, 1); half();
        check_val("pipe_a5", 32'(hrdata), 32'hA5);
        check_val("pipe_ok_a", 32'(hresp), 32'd0);
        tick();
        set_addr(0, 0); half();
        check_val("pipe_3c", 32'(hrdata), 32'h3C);
        check_val("pipe_ok_b", 32'(hresp), 32'd0);
        tick();

        // Unmapped region -> default slave two-cycle ERROR
        set_addr(3, 1); half();
        check_val("unmap_hsel", 32'(hsel_s), 32'd0);
        tick();
        set_addr(1, 1); half();
        check_val("err1_hready", 32'(hready), 32'd0);
        check_val("err1_hresp", 32'(hresp), 32'd1);
        check_val("err1_cnt", 32'(err_cnt), 32'd0);
        tick();
        half();
        check_val("err2_hready", 32'(hready), 32'd1);
        check_val("err2_hresp", 32'(hresp), 32'd1);
        tick();
        set_addr(0, 0); half();
        check_val("after_err_ok", 32'(hresp), 32'd0);
        check_val("after_err_cnt", 32'(err_cnt), 32'd1);
        tick();

        // Five wait states, no abort
        set_addr(2, 1); step();
        set_addr(0, 0);
        hreadyout_s[2] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            half();
            check_val("ws_hready", 32'(hready), 32'd0);
            check_val("ws_tevt", 32'(timeout_evt), 32'd0);
            tick();
        end
        hreadyout_s[2] = 1'b1;
        half();
        check_val("ws_done", 32'(hready), 32'd1);
        check_val("ws_okay", 32'(hresp), 32'd0);
        tick();

        // Watchdog abort on a permanently stalled slave
        cnt0 = m_cnt;
        set_addr(1, 1); step();
        set_addr(0, 0);
        hreadyout_s[1] = 1'b0;
        for (int i = 0; i < TO; i++) begin
            half();
            check_val("wd_wait", 32'(hready), 32'd0);
            tick();
        end
        half();
        check_val("wd_err1_hready", 32'(hready), 32'd0);
        check_val("wd_err1_hresp", 32'(hresp), 32'd1);
        tick();
        half();
        check_val("wd_err2_hready", 32'(hready), 32'd1);
        check_val("wd_err2_hresp", 32'(hresp), 32'd1);
        check_val("wd_tevt", 32'(timeout_evt), 32'd1);
        tick();
        half();
        check_val("wd_cnt", 32'(err_cnt), 32'(cnt0 + 1));
        check_val("wd_tevt_gone", 32'(timeout_evt), 32'd0);
        tick();
        hreadyout_s[1] = 1'b1;

        // Reset in the middle of a stalled transfer
        set_addr(2, 1); step();
        set_addr(0, 0);
        hreadyout_s[2] = 1'b0;
        step();
        apply_reset();
        hreadyout_s = '1;

        // err_cnt saturation
        set_addr(3, 1);
        for (int i = 0; i < 610; i++) step();
        half();
        check_val("sat_cnt", 32'(err_cnt), 32'd255);
        tick();
        set_addr(0, 0);
        apply_reset();

        // Randomised traffic with occasional long stalls and resets
        stall = 0;
        for (int i = 0; i < 2000; i++) begin
            haddr  = AW'($urandom);
            htrans = 2'($urandom);
            for (int k = 0; k < NS; k++) begin
                slv_data[k]    = DW'($urandom);
                hresp_s[k]     = ($urandom_range(0, 7) == 0);
                hreadyout_s[k] = ($urandom_range(0, 3) != 0);
            end
            if (stall == 0 && $urandom_range(0, 60) == 0) stall = $urandom_range(3, 12);
            if (stall > 0) begin
                hreadyout_s = '0;
                stall--;
            end
            if ($urandom_range(0, 400) == 0) apply_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
